// File: rtl/mpu_mult_scheduler.sv
// -----------------------------------------------------------------------------
// mpu_mult_scheduler
//
// Sequencer for the MPU_MULT instruction: dest = src0 x src1 (MxN times NxM)
// over the matrix register file. It uses one shared FMA unit and issues
// M*M*N serial fused multiply-adds. Each finished element is parked in an
// internal result buffer. The buffer is written back to the register file
// only after the last FMA completes, so dest may alias either source.
//
// Ports
//   clk, rst                      single clock, synchronous active-high reset
//   start_in, src_addr_0_in,      multiply request from decode; sampled in IDLE
//   src_addr_1_in, dest_addr_in
//   busy_out, done_out            busy outside IDLE; one-cycle completion pulse
//   rd_en_out, rd0_*/rd1_*        register-file read request (A[i][k], B[k][j])
//   rd0_data_in, rd1_data_in      read data, valid one cycle after rd_en_out
//   fma_valid_out/fma_ready_in    FMA request handshake, operands a*b+c
//   fma_a/b/c_out
//   fma_result_valid_in/_in       FMA result return
//   wr_en_out, wr_*_out           register-file write-back, raster order
// -----------------------------------------------------------------------------
module mpu_mult_scheduler #(
   parameter int M                = 3,
   parameter int N                = 3,
   parameter int MATRIX_REGISTERS = 8,
   parameter int FP               = 32,
   localparam int AW      = $clog2(MATRIX_REGISTERS),
   localparam int DIM_MAX = (M > N) ? M : N,
   localparam int IW      = (DIM_MAX > 1) ? $clog2(DIM_MAX) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_in,
   input  logic [AW-1:0] src_addr_0_in,
   input  logic [AW-1:0] src_addr_1_in,
   input  logic [AW-1:0] dest_addr_in,
   output logic          busy_out,
   output logic          done_out,
   output logic          rd_en_out,
   output logic [AW-1:0] rd0_addr_out,
   output logic [AW-1:0] rd1_addr_out,
   output logic [IW-1:0] rd0_row_out,
   output logic [IW-1:0] rd0_col_out,
   output logic [IW-1:0] rd1_row_out,
   output logic [IW-1:0] rd1_col_out,
   input  logic [FP-1:0] rd0_data_in,
   input  logic [FP-1:0] rd1_data_in,
   output logic          fma_valid_out,
   input  logic          fma_ready_in,
   output logic [FP-1:0] fma_a_out,
   output logic [FP-1:0] fma_b_out,
   output logic [FP-1:0] fma_c_out,
   input  logic          fma_result_valid_in,
   input  logic [FP-1:0] fma_result_in,
   output logic          wr_en_out,
   output logic [AW-1:0] wr_addr_out,
   output logic [IW-1:0] wr_row_out,
   output logic [IW-1:0] wr_col_out,
   output logic [FP-1:0] wr_data_out
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] i_q, i_d;
   logic [IW-1:0] j_q, j_d;
   logic [IW-1:0] k_q, k_d;
   logic [AW-1:0] src0_q, src0_d;
   logic [AW-1:0] src1_q, src1_d;
   logic [AW-1:0] dest_q, dest_d;
   logic [FP-1:0] acc_q, acc_d;
   logic [IW-1:0] wr_row_q, wr_row_d;
   logic [IW-1:0] wr_col_q, wr_col_d;
   // Operand holding registers: the first ISSUE cycle forwards the fresh read
   // data; if the FMA stalls, the captured copy keeps a/b stable.
   logic [FP-1:0] a_q, b_q;
   logic          hold_q;
   logic          buf_we;

   logic [FP-1:0] res_buf_q [M][M];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         i_q      <= '0;
         j_q      <= '0;
         k_q      <= '0;
         src0_q   <= '0;
         src1_q   <= '0;
         dest_q   <= '0;
         acc_q    <= '0;
         wr_row_q <= '0;
         wr_col_q <= '0;
         a_q      <= '0;
         b_q      <= '0;
         hold_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         i_q      <= i_d;
         j_q      <= j_d;
         k_q      <= k_d;
         src0_q   <= src0_d;
         src1_q   <= src1_d;
         dest_q   <= dest_d;
         acc_q    <= acc_d;
         wr_row_q <= wr_row_d;
         wr_col_q <= wr_col_d;
         if (state_q == S_ISSUE && !hold_q) begin
            a_q <= rd0_data_in;
            b_q <= rd1_data_in;
         end
         hold_q <= (state_q == S_ISSUE) && !fma_ready_in;
      end
   end

   // Result buffer: plain storage, no reset needed (always fully written
   // before it is read back).
   always_ff @(posedge clk) begin
      if (buf_we) begin
         res_buf_q[i_q][j_q] <= fma_result_in;
      end
   end

   always_comb begin
      state_d       = state_q;
      i_d           = i_q;
      j_d           = j_q;
      k_d           = k_q;
      src0_d        = src0_q;
      src1_d        = src1_q;
      dest_d        = dest_q;
      acc_d         = acc_q;
      wr_row_d      = wr_row_q;
      wr_col_d      = wr_col_q;
      buf_we        = 1'b0;
      busy_out      = (state_q != S_IDLE);
      done_out      = 1'b0;
      rd_en_out     = 1'b0;
      rd0_addr_out  = '0;
      rd1_addr_out  = '0;
      rd0_row_out   = '0;
      rd0_col_out   = '0;
      rd1_row_out   = '0;
      rd1_col_out   = '0;
      fma_valid_out = 1'b0;
      fma_a_out     = '0;
      fma_b_out     = '0;
      fma_c_out     = '0;
      wr_en_out     = 1'b0;
      wr_addr_out   = '0;
      wr_row_out    = '0;
      wr_col_out    = '0;
      wr_data_out   = '0;

      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               state_d  = S_READ;
               src0_d   = src_addr_0_in;
               src1_d   = src_addr_1_in;
               dest_d   = dest_addr_in;
               i_d      = '0;
               j_d      = '0;
               k_d      = '0;
               wr_row_d = '0;
               wr_col_d = '0;
            end
         end

         S_READ: begin
            rd_en_out    = 1'b1;
            rd0_addr_out = src0_q;
            rd0_row_out  = i_q;
            rd0_col_out  = k_q;
            rd1_addr_out = src1_q;
            rd1_row_out  = k_q;
            rd1_col_out  = j_q;
            state_d      = S_ISSUE;
         end

         S_ISSUE: begin
            fma_valid_out = 1'b1;
            fma_a_out     = hold_q ? a_q : rd0_data_in;
            fma_b_out     = hold_q ? b_q : rd1_data_in;
            // First product of an element starts the sum from +0.0.
            fma_c_out     = (k_q == '0) ? '0 : acc_q;
            if (fma_ready_in) begin
               state_d = S_WAIT;
            end
         end

         S_WAIT: begin
            if (fma_result_valid_in) begin
               if (k_q != IW'(N - 1)) begin
                  acc_d   = fma_result_in;
                  k_d     = k_q + IW'(1);
                  state_d = S_READ;
               end else begin
                  buf_we = 1'b1;
                  k_d    = '0;
                  if (j_q != IW'(M - 1)) begin
                     j_d     = j_q + IW'(1);
                     state_d = S_READ;
                  end else begin
                     j_d = '0;
                     if (i_q != IW'(M - 1)) begin
                        i_d     = i_q + IW'(1);
                        state_d = S_READ;
                     end else begin
                        i_d      = '0;
                        wr_row_d = '0;
                        wr_col_d = '0;
                        state_d  = S_WRITE;
                     end
                  end
               end
            end
         end

         S_WRITE: begin
            wr_en_out   = 1'b1;
            wr_addr_out = dest_q;
            wr_row_out  = wr_row_q;
            wr_col_out  = wr_col_q;
            wr_data_out = res_buf_q[wr_row_q][wr_col_q];
            if (wr_col_q != IW'(M - 1)) begin
               wr_col_d = wr_col_q + IW'(1);
            end else begin
               wr_col_d = '0;
               if (wr_row_q != IW'(M - 1)) begin
                  wr_row_d = wr_row_q + IW'(1);
               end else begin
                  wr_row_d = '0;
                  state_d  = S_DONE;
               end
            end
         end

         S_DONE: begin
            done_out = 1'b1;
            state_d  = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mpu_mult_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mpu_mult_scheduler
//
// Bench for mpu_mult_scheduler with a behavioural register file (registered
// read) and an integer-valued FMA model with programmable latency. Expected
// write-backs are pushed to a scoreboard at start and popped on each write.
// -----------------------------------------------------------------------------
module tb_mpu_mult_scheduler;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_in;
   logic [2:0]  src_addr_0_in, src_addr_1_in, dest_addr_in;
   logic        busy_out, done_out, rd_en_out;
   logic [2:0]  rd0_addr_out, rd1_addr_out;
   logic [1:0]  rd0_row_out, rd0_col_out, rd1_row_out, rd1_col_out;
   logic [31:0] rd0_data_in, rd1_data_in;
   logic        fma_valid_out, fma_ready_in;
   logic [31:0] fma_a_out, fma_b_out, fma_c_out;
   logic        fma_result_valid_in;
   logic [31:0] fma_result_in;
   logic        wr_en_out;
   logic [2:0]  wr_addr_out;
   logic [1:0]  wr_row_out, wr_col_out;
   logic [31:0] wr_data_out;

   mpu_mult_scheduler dut (
      .clk                 (clk),
      .rst                 (rst),
      .start_in            (start_in),
      .src_addr_0_in       (src_addr_0_in),
      .src_addr_1_in       (src_addr_1_in),
      .dest_addr_in        (dest_addr_in),
      .busy_out            (busy_out),
      .done_out            (done_out),
      .rd_en_out           (rd_en_out),
      .rd0_addr_out        (rd0_addr_out),
      .rd1_addr_out        (rd1_addr_out),
      .rd0_row_out         (rd0_row_out),
      .rd0_col_out         (rd0_col_out),
      .rd1_row_out         (rd1_row_out),
      .rd1_col_out         (rd1_col_out),
      .rd0_data_in         (rd0_data_in),
      .rd1_data_in         (rd1_data_in),
      .fma_valid_out       (fma_valid_out),
      .fma_ready_in        (fma_ready_in),
      .fma_a_out           (fma_a_out),
      .fma_b_out           (fma_b_out),
      .fma_c_out           (fma_c_out),
      .fma_result_valid_in (fma_result_valid_in),
      .fma_result_in       (fma_result_in),
      .wr_en_out           (wr_en_out),
      .wr_addr_out         (wr_addr_out),
      .wr_row_out          (wr_row_out),
      .wr_col_out          (wr_col_out),
      .wr_data_out         (wr_data_out)
   );

   int n_cmp = 0;
   int n_err = 0;

   // ---------------------------------------------------------------- helpers
   function automatic int f2i(input logic [31:0] f);
      int e;
      if (f[30:0] == 31'd0) return 0;
      e = int'(f[30:23]) - 127;
      return int'({8'd0, 1'b1, f[22:0]}) >> (23 - e);
   endfunction

   function automatic logic [31:0] i2f(input int n);
      int          p;
      logic [31:0] m;
      logic [31:0] nv;
      logic [7:0]  ex;
      if (n == 0) return 32'h0;
      nv = 32'(n);
      p  = 0;
      for (int b = 0; b < 31; b++) if (nv[b]) p = b;
      m  = nv << (23 - p);
      ex = 8'(p + 127);
      return {1'b0, ex, m[22:0]};
   endfunction

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ------------------------------------------- register file and FMA model
   logic [31:0] rf [8][9];
   logic        ld_en;
   logic [2:0]  ld_reg;
   int          ld_idx;
   logic [31:0] ld_val;
   logic [31:0] rd0_q, rd1_q;
   int          cyc = 0;
   int          lat;
   int          res_cnt = 0;
   logic [31:0] res_val = 32'h0;
   int          acc_cnt = 0;
   logic        stray;

   assign rd0_data_in         = rd0_q;
   assign rd1_data_in         = rd1_q;
   assign fma_result_valid_in = (res_cnt == 1) || stray;
   assign fma_result_in       = (res_cnt == 1) ? res_val : 32'hdeadbeef;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (ld_en) rf[ld_reg][ld_idx] <= ld_val;
      if (rd_en_out) begin
         rd0_q <= rf[rd0_addr_out][int'(rd0_row_out) * 3 + int'(rd0_col_out)];
         rd1_q <= rf[rd1_addr_out][int'(rd1_row_out) * 3 + int'(rd1_col_out)];
      end
      if (wr_en_out) rf[wr_addr_out][int'(wr_row_out) * 3 + int'(wr_col_out)] <= wr_data_out;
      if (rst) begin
         res_cnt <= 0;
      end else if (fma_valid_out && fma_ready_in) begin
         res_cnt <= lat;
         res_val <= i2f(f2i(fma_a_out) * f2i(fma_b_out) + f2i(fma_c_out));
         acc_cnt <= acc_cnt + 1;
      end else if (res_cnt != 0) begin
         res_cnt <= res_cnt - 1;
      end
   end

   // --------------------------------------------------------- output monitor
   logic [38:0] sb [$];
   int          wr_cnt = 0, wr_first = 0, wr_last = 0, done_cnt = 0, stab_cnt = 0;
   logic        prev_wr = 1'b0, stalled = 1'b0;
   logic [95:0] held_ops = '0;

   always @(negedge clk) begin
      if (wr_en_out) begin
         wr_cnt++;
         if (!prev_wr) wr_first = cyc;
         wr_last = cyc;
         if (sb.size() == 0) begin
            chk("wr_unexpected", 160'(wr_en_out), 160'(0));
         end else begin
            logic [38:0] e;
            e = sb.pop_front();
            chk("wr_elem", 160'({wr_addr_out, wr_row_out, wr_col_out, wr_data_out}), 160'(e));
            $display("write reg%0d[%0d][%0d] = %h (cycle %0d)", wr_addr_out, wr_row_out,
                     wr_col_out, wr_data_out, cyc);
         end
      end
      prev_wr = wr_en_out;
      if (done_out) done_cnt++;
      if (fma_valid_out && !rst) begin
         if (stalled) begin
            stab_cnt++;
            chk("fma_ops_stable", 160'({fma_a_out, fma_b_out, fma_c_out}), 160'(held_ops));
         end
         stalled  = !fma_ready_in;
         held_ops = {fma_a_out, fma_b_out, fma_c_out};
      end else begin
         stalled = 1'b0;
      end
   end

   logic [153:0] all_outs;
   assign all_outs = {busy_out, done_out, rd_en_out, rd0_addr_out, rd1_addr_out, rd0_row_out,
                      rd0_col_out, rd1_row_out, rd1_col_out, fma_valid_out, fma_a_out,
                      fma_b_out, fma_c_out, wr_en_out, wr_addr_out, wr_row_out, wr_col_out,
                      wr_data_out};

   // ------------------------------------------------------------- stimulus
   int start_cyc = 0;
   int seq_exp   [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
   int alias_exp [9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_reg(input logic [2:0] r, input bit ident);
      for (int idx = 0; idx < 9; idx++) begin
         ld_en  = 1'b1;
         ld_reg = r;
         ld_idx = idx;
         ld_val = ident ? ((idx % 4 == 0) ? i2f(1) : 32'h0) : i2f(idx + 1);
         tick();
      end
      ld_en = 1'b0;
   endtask

   task automatic start_mult(input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] d);
      int sum;
      for (int i = 0; i < 3; i++) begin
         for (int j = 0; j < 3; j++) begin
            sum = 0;
            for (int k = 0; k < 3; k++)
               sum += f2i(rf[s0][i * 3 + k]) * f2i(rf[s1][k * 3 + j]);
            sb.push_back({d, 2'(i), 2'(j), i2f(sum)});
         end
      end
      start_in      = 1'b1;
      src_addr_0_in = s0;
      src_addr_1_in = s1;
      dest_addr_in  = d;
      start_cyc     = cyc;
      $display("start src0=%0d src1=%0d dest=%0d at cycle %0d (L=%0d)", s0, s1, d, cyc, lat);
      tick();
      start_in = 1'b0;
   endtask

   task automatic wait_done(input int exp_rel, input string tag);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < 400 && !seen; n++) begin
         @(negedge clk);
         if (done_out) begin
            seen = 1'b1;
            $display("done at relative cycle %0d", cyc - start_cyc);
            chk(tag, 160'(cyc - start_cyc), 160'(exp_rel));
         end
      end
      if (!seen) chk({tag, "_timeout"}, 160'(0), 160'(1));
      chk({tag, "_sb_empty"}, 160'(sb.size()), 160'(0));
   endtask

   task automatic check_reg(input int r, input int vals [9], input string tag);
      for (int idx = 0; idx < 9; idx++) chk(tag, 160'(rf[r][idx]), 160'(i2f(vals[idx])));
   endtask

   initial begin
      int w0, a0, s0, d0;
      rst = 1'b1; start_in = 1'b0; src_addr_0_in = '0; src_addr_1_in = '0; dest_addr_in = '0;
      fma_ready_in = 1'b1; lat = 1; stray = 1'b0;
      ld_en = 1'b0; ld_reg = '0; ld_idx = 0; ld_val = '0;
      repeat (3) tick();
      chk("reset_outputs", 160'(all_outs), 160'(0));
      rst = 1'b0;
      load_reg(3'd0, 1'b1);
      load_reg(3'd1, 1'b0);
      load_reg(3'd3, 1'b0);
      tick();

      // Identity multiply, L=1
      w0 = wr_cnt;
      start_mult(3'd0, 3'd1, 3'd2);
      wait_done(91, "ident_done_cycle");
      chk("ident_wr_count", 160'(wr_cnt - w0), 160'(9));
      chk("ident_wr_consecutive", 160'(wr_last - wr_first), 160'(8));
      check_reg(2, seq_exp, "ident_reg2");

      // Full aliasing, started in the IDLE cycle directly after DONE
      tick();
      start_mult(3'd3, 3'd3, 3'd3);
      wait_done(91, "alias_done_cycle");
      check_reg(3, alias_exp, "alias_reg3");

      // Backpressure: ready low for 3 cycles at the first ISSUE (cycle 2)
      tick();
      a0 = acc_cnt; s0 = stab_cnt;
      start_mult(3'd0, 3'd1, 3'd2);
      tick();
      fma_ready_in = 1'b0;
      repeat (3) tick();
      fma_ready_in = 1'b1;
      wait_done(94, "bp_done_cycle");
      chk("bp_accepts", 160'(acc_cnt - a0), 160'(27));
      chk("bp_stable_checks", 160'(stab_cnt - s0), 160'(3));
      check_reg(2, seq_exp, "bp_reg2");

      // Second start at cycle 10 with other addresses is dropped
      tick();
      start_mult(3'd1, 3'd0, 3'd4);
      repeat (9) tick();
      start_in = 1'b1; src_addr_0_in = 3'd0; src_addr_1_in = 3'd0; dest_addr_in = 3'd5;
      tick();
      start_in = 1'b0;
      wait_done(91, "filter_done_cycle");
      check_reg(4, seq_exp, "filter_reg4");

      // Reset at cycle 20 aborts the operation
      tick();
      d0 = done_cnt; w0 = wr_cnt;
      start_mult(3'd0, 3'd1, 3'd6);
      repeat (19) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      @(negedge clk);
      chk("abort_outputs_zero", 160'(all_outs), 160'(0));
      repeat (120) tick();
      chk("abort_no_done", 160'(done_cnt - d0), 160'(0));
      chk("abort_no_write", 160'(wr_cnt - w0), 160'(0));
      start_mult(3'd0, 3'd1, 3'd2);
      wait_done(91, "post_reset_done_cycle");
      check_reg(2, seq_exp, "post_reset_reg2");

      // L=4 with a stray result pulse during the second READ (cycle 7)
      tick();
      lat = 4;
      start_mult(3'd0, 3'd1, 3'd7);
      repeat (6) tick();
      chk("stray_in_read", 160'(rd_en_out), 160'(1));
      stray = 1'b1;
      tick();
      stray = 1'b0;
      wait_done(172, "lat4_done_cycle");
      check_reg(7, seq_exp, "lat4_reg7");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
